// File: rtl/deu_gpr_file.sv
// Parametrised GPR file for the decode/execute unit. It has N read and M write ports,
// highest-port-wins writes, an optional same-cycle bypass and a pending scoreboard.
module deu_gpr_file #(
    parameter int DATA_W    = 64,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 3,
    parameter int NUM_ALLOC = 2,
    parameter int BYPASS    = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD-1:0]           re,
    input  logic [NUM_RD*ADDR_W-1:0]    raddr,
    output logic [NUM_RD*DATA_W-1:0]    rdata,
    output logic [NUM_RD-1:0]           rrdy,
    input  logic [NUM_WR-1:0]           we,
    input  logic [NUM_WR*ADDR_W-1:0]    waddr,
    input  logic [NUM_WR*DATA_W-1:0]    wdata,
    input  logic [NUM_ALLOC-1:0]        alloc_v,
    input  logic [NUM_ALLOC*ADDR_W-1:0] alloc_addr,
    input  logic                        flush,
    output logic [NUM_REGS-1:0]         pending,
    output logic [ADDR_W:0]             pend_cnt
);

    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [ADDR_W:0]     r_cnt;

    logic [NUM_REGS-1:0] w_wr_hit;
    logic [DATA_W-1:0]   w_wr_data [NUM_REGS];
    logic [NUM_REGS-1:0] w_al_hit;
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic [ADDR_W-1:0]   w_ra [NUM_RD];

    // Register 0 and addresses beyond the file are never stored or tracked.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS);
    endfunction

    // Write decode: later (higher-index) ports overwrite earlier hits.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i]  = 1'b0;
            w_wr_data[i] = '0;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
                    w_wr_hit[i]  = 1'b1;
                    w_wr_data[i] = wdata[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Scoreboard next state: writeback clears, allocate sets, flush clears all.
    always_comb begin
        w_al_hit   = '0;
        w_pend_nxt = '0;
        w_cnt_nxt  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int a = 0; a < NUM_ALLOC; a++) begin
                if (alloc_v[a] && (alloc_addr[a*ADDR_W +: ADDR_W] == ADDR_W'(i)))
                    w_al_hit[i] = 1'b1;
            end
            w_pend_nxt[i] = !flush && (w_al_hit[i] || (r_pend[i] && !w_wr_hit[i]));
            w_cnt_nxt     = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
        end
    end

    // Read ports
    always_comb begin
        rdata = '0;
        rrdy  = '1;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra[k] = raddr[k*ADDR_W +: ADDR_W];
            if (re[k] && addr_ok(w_ra[k])) begin
                rdata[k*DATA_W +: DATA_W] = r_regs[w_ra[k]];
                rrdy[k]                   = !r_pend[w_ra[k]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == w_ra[k])) begin
                            rdata[k*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
                            rrdy[k]                   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // State update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i])
                    r_regs[i] <= w_wr_data[i];
            end
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign pending  = r_pend;
    assign pend_cnt = r_cnt;

endmodule
